// File: rtl/led_pwm_ctrl_if.sv
// Native CPU memory bus: single outstanding request, held until mem_ready.
interface led_pwm_ctrl_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED controller: static, PWM and blink modes behind a
// memory-mapped register window with one wait state per access.
module led_pwm_ctrl #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0010
) (
    input  logic              clk,
    input  logic              reset,
    led_pwm_ctrl_if.slave     bus,
    output logic [NUM_CH-1:0] led
);
    localparam logic [31:0] WIN_BYTES = 32'(16 + 4 * NUM_CH);

    logic [NUM_CH-1:0]    out_q, out_d;
    logic [2*NUM_CH-1:0]  mode_q, mode_d;
    logic [15:0]          presc_q, presc_d;
    logic [15:0]          pcnt_q, pcnt_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 phase_q, phase_d;
    logic [CNT_WIDTH-1:0] duty_q [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_d [NUM_CH];
    logic [NUM_CH-1:0]    led_q, led_d;
    logic                 ready_q, ready_d;
    logic [31:0]          rdata_q, rdata_d;

    logic [31:0] offset;
    logic [5:0]  widx;
    logic        sel, acc, wr, presc_wr, tick;
    logic [31:0] rd_val;

    function automatic logic [31:0] merge_strb(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
        end
        return r;
    endfunction

    assign offset = bus.mem_addr - BASE_ADDR;
    assign widx   = offset[7:2];
    assign sel    = bus.mem_valid && (bus.mem_addr >= BASE_ADDR) &&
                    (offset < WIN_BYTES) && (bus.mem_addr[1:0] == 2'b00);

    always_comb begin
        // A request is taken only in its first cycle; the ack cycle never re-commits.
        acc      = sel && !ready_q;
        wr       = acc && (bus.mem_wstrb != 4'b0000);
        presc_wr = wr && (widx == 6'd2);

        rd_val = '0;
        case (widx)
            6'd0:    rd_val = 32'(out_q);
            6'd1:    rd_val = 32'(mode_q);
            6'd2:    rd_val = 32'(presc_q);
            6'd3:    rd_val = 32'(cnt_q);
            default: rd_val = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (widx == 6'(i + 4)) rd_val = 32'(duty_q[i]);
        end

        out_d   = out_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        duty_d  = duty_q;
        if (wr) begin
            case (widx)
                6'd0: out_d   = NUM_CH'(merge_strb(32'(out_q), bus.mem_wdata, bus.mem_wstrb));
                6'd1: mode_d  = (2*NUM_CH)'(merge_strb(32'(mode_q), bus.mem_wdata, bus.mem_wstrb));
                6'd2: presc_d = 16'(merge_strb(32'(presc_q), bus.mem_wdata, bus.mem_wstrb));
                default: ;
            endcase
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr && (widx == 6'(i + 4))) begin
                duty_d[i] = CNT_WIDTH'(merge_strb(32'(duty_q[i]), bus.mem_wdata, bus.mem_wstrb));
            end
        end

        // A PRESC write restarts the prescaler and swallows a coincident tick.
        tick    = (pcnt_q == presc_q);
        pcnt_d  = pcnt_q + 16'd1;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (presc_wr) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == '1) phase_d = ~phase_q;
        end

        led_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode_q[2*i +: 2])
                2'b00:   led_d[i] = out_q[i];
                2'b01:   led_d[i] = (cnt_q < duty_q[i]);
                2'b10:   led_d[i] = out_q[i] & phase_q;
                default: led_d[i] = 1'b0;
            endcase
        end

        ready_d = acc;
        rdata_d = acc ? rd_val : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            mode_q  <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
            led_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            for (int i = 0; i < NUM_CH; i++) duty_q[i] <= duty_d[i];
            led_q   <= led_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign led           = led_q;
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl: register access, PWM duty, blink period,
// prescaler restart and reset behaviour with hand-computed expectations.
module tb_led_pwm_ctrl;
    localparam logic [31:0] A_OUT   = 32'h0200_0010;
    localparam logic [31:0] A_MODE  = 32'h0200_0014;
    localparam logic [31:0] A_PRESC = 32'h0200_0018;
    localparam logic [31:0] A_CNT   = 32'h0200_001C;
    localparam logic [31:0] A_DUTY0 = 32'h0200_0020;
    localparam logic [31:0] A_DUTY3 = 32'h0200_002C;
    localparam logic [31:0] A_BEYOND = 32'h0200_0030;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] led;
    int         checks = 0;
    int         failures = 0;

    led_pwm_ctrl_if bus();

    led_pwm_ctrl #(
        .NUM_CH    (4),
        .CNT_WIDTH (8),
        .BASE_ADDR (32'h0200_0010)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .led   (led)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, output logic [31:0] rd);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        bus.mem_wstrb = strb;
        @(posedge clk); #1;
        chk("ack", {31'b0, bus.mem_ready}, 32'd1);
        rd = bus.mem_rdata;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        @(posedge clk); #1;
        chk("ack_once", {31'b0, bus.mem_ready}, 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    task automatic count_high(output int c);
        c = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            if (led[0]) c++;
        end
    endtask

    task automatic wait_edge(output int n, output logic got);
        logic prev;
        prev = led[0];
        n    = 0;
        got  = 1'b0;
        for (int k = 0; k < 2100; k++) begin
            @(posedge clk); #1;
            n++;
            if (led[0] !== prev) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd, c0, r1, r2, r3, r4, r5;
        int          hi, n;
        logic        got;

        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;

        chk("rst_ready", {31'b0, bus.mem_ready}, 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_led", {28'b0, led}, 32'd0);

        // Register access and strobes
        xfer(A_OUT, 32'h0000_000A, 4'b1111, rd);
        xfer(A_OUT, 32'h0, 4'b0000, rd);
        chk("out_readback", rd, 32'h0000_000A);
        chk("led_static", {28'b0, led}, 32'h0000_000A);

        xfer(A_MODE, 32'hFFFF_FFFF, 4'b1111, rd);
        xfer(A_MODE, 32'h0, 4'b0000, rd);
        chk("mode_width", rd, 32'h0000_00FF);
        xfer(A_MODE, 32'h0, 4'b1111, rd);

        xfer(A_PRESC, 32'hFFFF_FF05, 4'b0001, rd);
        xfer(A_PRESC, 32'h0, 4'b0000, rd);
        chk("presc_strb", rd, 32'h0000_0005);

        xfer(A_DUTY0, 32'h0000_1234, 4'b0010, rd);
        xfer(A_DUTY0, 32'h0, 4'b0000, rd);
        chk("duty_hi_byte_ignored", rd, 32'h0000_0000);
        xfer(A_DUTY0, 32'hFFFF_FFAB, 4'b0001, rd);
        xfer(A_DUTY0, 32'h0, 4'b0000, rd);
        chk("duty_lo_byte", rd, 32'h0000_00AB);

        bus.mem_valid = 1'b1;
        bus.mem_addr  = A_BEYOND;
        bus.mem_wstrb = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("beyond_ready", {31'b0, bus.mem_ready}, 32'd0);
            chk("beyond_rdata", bus.mem_rdata, 32'd0);
        end
        bus.mem_valid = 1'b0;

        // PWM with tick every cycle
        xfer(A_PRESC, 32'h0, 4'b1111, rd);
        xfer(A_DUTY0, 32'd64, 4'b1111, rd);
        xfer(A_MODE, 32'h0000_0001, 4'b1111, rd);
        chk("pwm_other_ch", {29'b0, led[3:1]}, 32'h5);
        count_high(hi);
        chk("duty64", 32'(hi), 32'd64);

        xfer(A_CNT, 32'h0, 4'b0000, r1);
        xfer(A_CNT, 32'h0, 4'b0000, r2);
        chk("cnt_rate", (r2 - r1) & 32'hFF, 32'd2);

        xfer(A_DUTY0, 32'd0, 4'b1111, rd);
        count_high(hi);
        chk("duty0", 32'(hi), 32'd0);
        xfer(A_DUTY0, 32'd255, 4'b1111, rd);
        count_high(hi);
        chk("duty255", 32'(hi), 32'd255);

        // PRESC write lands on a tick edge (PRESC=0 ticks every cycle)
        xfer(A_CNT, 32'h0, 4'b0000, c0);
        xfer(A_PRESC, 32'd3, 4'b1111, rd);
        xfer(A_CNT, 32'h0, 4'b0000, r1);
        xfer(A_CNT, 32'h0, 4'b0000, r2);
        xfer(A_CNT, 32'h0, 4'b0000, r3);
        xfer(A_CNT, 32'h0, 4'b0000, r4);
        xfer(A_CNT, 32'h0, 4'b0000, r5);
        chk("presc_wr_no_tick", r1, (c0 + 32'd2) & 32'hFF);
        chk("presc_wr_hold", r2, (c0 + 32'd2) & 32'hFF);
        chk("first_tick", r3, (c0 + 32'd3) & 32'hFF);
        chk("tick_period_a", r4, (c0 + 32'd3) & 32'hFF);
        chk("tick_period_b", r5, (c0 + 32'd4) & 32'hFF);

        // Blink: ch0 blink, ch1 forced off, ch2 static, ch3 PWM with DUTY=0
        pulse_reset();
        xfer(A_PRESC, 32'd3, 4'b1111, rd);
        xfer(A_OUT, 32'h0000_000F, 4'b1111, rd);
        xfer(A_MODE, 32'h0000_004E, 4'b1111, rd);
        chk("mixed_modes", {29'b0, led[3:1]}, 32'h2);
        wait_edge(n, got);
        chk("blink_first_edge", {31'b0, got}, 32'd1);
        wait_edge(n, got);
        chk("blink_half_period_a", 32'(n), 32'd1024);
        wait_edge(n, got);
        chk("blink_half_period_b", 32'(n), 32'd1024);

        // Reset coincident with a write request
        reset         = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = A_OUT;
        bus.mem_wdata = 32'h0000_000F;
        bus.mem_wstrb = 4'b1111;
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        chk("abort_ready", {31'b0, bus.mem_ready}, 32'd0);
        chk("abort_rdata", bus.mem_rdata, 32'd0);
        chk("abort_led", {28'b0, led}, 32'd0);
        @(posedge clk); #1;
        chk("abort_ready_next", {31'b0, bus.mem_ready}, 32'd0);
        xfer(A_OUT, 32'h0, 4'b0000, rd);
        chk("abort_out", rd, 32'd0);

        // CNT is read-only
        xfer(A_PRESC, 32'h0000_FFFF, 4'b1111, rd);
        xfer(A_CNT, 32'h0, 4'b0000, r1);
        xfer(A_CNT, 32'h0000_0055, 4'b1111, rd);
        xfer(A_CNT, 32'h0, 4'b0000, r2);
        chk("cnt_readonly", r2, r1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
